ones_pattern_gen: RTL and testbench
===================================

Name: ones_pattern_gen

Overview:
- Inverse of the team's combinational ones-counter. The counter maps a word to its popcount; this block takes a target popcount k and streams every WIDTH-bit word that has exactly k ones.
- Words are emitted in ascending numeric order, at most one per cycle, over a valid/ready handshake.
- Used as a stimulus source for popcount logic and as a combination enumerator.

Parameters:
- WIDTH, 8, bit width of generated words (2..16).
- CW, $clog2(WIDTH+1), width of the k input (derived; not to be overridden).
- IW, 16, width of the pattern index counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- k_in  in  CW  target number of ones; sampled with start.
- pat_out  out  WIDTH  current word.
- pat_valid  out  1  pat_out is valid.
- pat_ready  in  1  consumer accepts the word when pat_valid && pat_ready.
- pat_last  out  1  qualifies pat_out as the final word of the sequence.
- pat_idx  out  IW  0-based index of the current word.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last word is accepted.
- err  out  1  one-cycle pulse on illegal k_in, or sticky under the optional feature.

Behaviour:
- Reset: all outputs are 0 and the FSM goes to IDLE. Reset is asynchronous, so it takes effect mid-sequence without waiting for a handshake completion.
- FSM states: IDLE, RUN, FIN.
- IDLE, start with k_in <= WIDTH: go to RUN next cycle.
  - pat_out = (1<<k)-1, pat_valid = 1, pat_idx = 0.
  - Latency from start to first pat_valid is 1 cycle.
- IDLE, start with k_in > WIDTH: err pulses for 1 cycle, the FSM stays in IDLE and pat_valid stays 0.
- RUN: pat_out, pat_last and pat_idx are held stable while pat_valid && !pat_ready.
- RUN, on accept of a non-last word, load the next word by Gosper's rule, computed at WIDTH+1 bits:
  - c = x & -x
  - r = x + c
  - next = (((r ^ x) >> 2) >> tz(c)) | r, where tz(c) is the trailing-zero count of c (no divider).
  - pat_idx increments on each accept.
  - Back-to-back accepts sustain 1 word per cycle.
- pat_last is high when pat_out equals ((1<<k)-1) << (WIDTH-k).
- RUN, on accept of the last word: go to FIN with pat_valid = 0.
- FIN: done pulses for 1 cycle, then the FSM returns to IDLE.
- Edge case k = 0: exactly one word, 0, with pat_last = 1.
- Edge case k = WIDTH: exactly one word, all ones, with pat_last = 1.
- start is ignored outside IDLE; k_in is not re-sampled.
- Total words emitted equals C(WIDTH,k). pat_idx saturates at 2^IW-1; this cannot be reached for WIDTH <= 16.
- pat_out remains at its last value when pat_valid = 0. Verification must not check pat_out while pat_valid is low.

Optional Feature:
- Macro: ONES_PATTERN_SELF_CHECK_EN.
- When defined:
  - An internal popcount of pat_out is compared with the latched k on every cycle with pat_valid high.
  - The ordering check requires each word to be strictly greater than the previous accepted word.
  - Any mismatch sets err sticky-high until reset or the next legal start.
- When undefined:
  - The checker logic is absent.
  - err is only the illegal-k pulse.

Decomposition:
- Package ones_pattern_pkg holds:
  - the state enum (IDLE, RUN, FIN);
  - localparam function clog2;
  - a constant function first_word(k, WIDTH);
  - a constant function last_word(k, WIDTH).
- One sub-module: ones_count_w, a parameterised WIDTH-in, CW-out combinational popcount.
  - Instantiated only under ONES_PATTERN_SELF_CHECK_EN.
  - Reusable by the team's counter benches.

Test Plan:
- WIDTH=8, k=1, pat_ready tied high: expect 8 words 01,02,04,...,80 on consecutive cycles, pat_last on 80, done one cycle after, pat_idx 0..7.
- WIDTH=8, k=2: expect 28 words 03,05,06,09,0A,0C,11,... ending C0. Bench popcount of every word is 2 and values are strictly ascending.
- k=0 yields the single word 00, and k=8 yields the single word FF. Both have pat_last=1 and done pulses once.
- k=9: err pulses for 1 cycle, busy stays 0 and pat_valid is never asserted.
- k=4 with random pat_ready (about 50%): 70 words total, pat_out held stable during stalls, and no word is dropped or duplicated.
- Reset mid-run:
  - Pulse rst_n low after the 10th word of k=3: outputs go to 0 immediately.
  - A new start with k=3 restarts at 07 with pat_idx=0.
  - With the self-check macro defined, err stays 0 throughout.

Source files
------------

// File: rtl/ones_pattern_pkg.sv
// rtl/ones_pattern_pkg.sv - FSM state type and word helpers for the ones pattern generator
package ones_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Smallest word with k ones; an out-of-range k yields 0.
  function automatic logic [31:0] first_word(input int k, input int width);
    if (k < 0 || k > width) return 32'd0;
    return (32'd1 << k) - 32'd1;
  endfunction

  // Largest word with k ones: the same run of ones packed against the MSB.
  function automatic logic [31:0] last_word(input int k, input int width);
    if (k < 0 || k > width) return 32'd0;
    return first_word(k, width) << (width - k);
  endfunction

endpackage

// File: rtl/ones_count_w.sv
// rtl/ones_count_w.sv - parameterised combinational popcount of a WIDTH-bit word
module ones_count_w #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] word_i,
  output logic [CW-1:0]    count_o
);

  always_comb begin
    count_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_o = count_o + CW'(word_i[i]);
    end
  end

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - streams every WIDTH-bit word with exactly k ones in ascending order
// Optional sticky popcount/ordering checker: ONES_PATTERN_SELF_CHECK_EN.
module ones_pattern_gen
  import ones_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = clog2(WIDTH + 1),
  parameter int IW    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    k_in,
  output logic [WIDTH-1:0] pat_out,
  output logic             pat_valid,
  input  logic             pat_ready,
  output logic             pat_last,
  output logic [IW-1:0]    pat_idx,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  pat_q, pat_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     k_q, k_d;
  logic              err_pulse_q;

  logic              k_legal, start_ok, start_bad, accept, last_hit;
  logic [WIDTH:0]    gx, gc, gr;
  logic [WIDTH-1:0]  gnext;
  logic [4:0]        tz;

  assign k_legal   = 32'(k_in) <= WIDTH;
  assign start_ok  = (state_q == IDLE) && start && k_legal;
  assign start_bad = (state_q == IDLE) && start && !k_legal;
  assign accept    = pat_valid && pat_ready;
  assign last_hit  = pat_q == WIDTH'(last_word(int'(k_q), WIDTH));

  // Gosper's successor, one bit wider so the carry out of the top is kept.
  always_comb begin
    gx = {1'b0, pat_q};
    gc = gx & (-gx);
    gr = gx + gc;
    tz = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (gc[i]) tz = 5'(i);
    end
    gnext = WIDTH'(((((gr ^ gx) >> 2) >> tz) | gr));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (accept && last_hit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pat_valid = (state_q == RUN);
    busy      = (state_q == RUN);
    done      = (state_q == FIN);
  end

  always_comb begin
    pat_d = pat_q;
    idx_d = idx_q;
    k_d   = k_q;
    if (start_ok) begin
      pat_d = WIDTH'(first_word(int'(k_in), WIDTH));
      idx_d = '0;
      k_d   = k_in;
    end else if (accept) begin
      if (!last_hit) pat_d = gnext;
      if (idx_q != '1) idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q       <= '0;
      idx_q       <= '0;
      k_q         <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      pat_q       <= pat_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      err_pulse_q <= start_bad;
    end
  end

  assign pat_out  = pat_q;
  assign pat_idx  = idx_q;
  assign pat_last = pat_valid && last_hit;

`ifdef ONES_PATTERN_SELF_CHECK_EN
  logic [CW-1:0]    pop;
  logic [WIDTH-1:0] prev_q;
  logic             have_prev_q, sticky_q, chk_bad;

  ones_count_w #(.WIDTH(WIDTH), .CW(CW)) u_pop (
    .word_i (pat_q),
    .count_o(pop)
  );

  assign chk_bad = pat_valid && ((pop != k_q) || (have_prev_q && (pat_q <= prev_q)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else if (start_ok) begin
      have_prev_q <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      sticky_q <= sticky_q | chk_bad;
      if (accept) begin
        prev_q      <= pat_q;
        have_prev_q <= 1'b1;
      end
    end
  end

  assign err = err_pulse_q | sticky_q;
`else
  assign err = err_pulse_q;
`endif

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - randomized self-checking bench against an enumerating reference model
module tb_ones_pattern_gen;

  localparam int WIDTH = 8;
  localparam int CW    = 4;
  localparam int IW    = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [CW-1:0]    k_in = '0;
  logic             pat_ready = 1'b0;
  logic [WIDTH-1:0] pat_out;
  logic             pat_valid, pat_last, busy, done, err;
  logic [IW-1:0]    pat_idx;

  ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .k_in     (k_in),
    .pat_out  (pat_out),
    .pat_valid(pat_valid),
    .pat_ready(pat_ready),
    .pat_last (pat_last),
    .pat_idx  (pat_idx),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Model: expected words are every value whose popcount equals k, ascending.
  logic [WIDTH-1:0] q[$];
  int               ph = 0;
  int               pos = 0;
  int               n_acc = 0;
  logic [WIDTH-1:0] first_seen = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(pat_valid), 0);
      chk("rst_out", 32'(pat_out), 0);
      chk("rst_idx", 32'(pat_idx), 0);
      chk("rst_last", 32'(pat_last), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_err", 32'(err), 0);
      ph  = 0;
      pos = 0;
    end else begin
      case (ph)
        0: begin
          chk("idle_valid", 32'(pat_valid), 0);
          chk("idle_busy", 32'(busy), 0);
          chk("idle_done", 32'(done), 0);
          chk("idle_err", 32'(err), 0);
          if (start) begin
            q.delete();
            for (int v = 0; v < (1 << WIDTH); v++)
              if ($countones(v) == int'(k_in)) q.push_back(WIDTH'(v));
            pos   = 0;
            n_acc = 0;
            ph    = (int'(k_in) <= WIDTH) ? 1 : 3;
          end
        end
        1: begin
          chk("run_valid", 32'(pat_valid), 1);
          chk("run_busy", 32'(busy), 1);
          chk("run_done", 32'(done), 0);
          chk("run_err", 32'(err), 0);
          if (!pat_valid) begin
            ph = 0;
          end else begin
            chk("run_word", 32'(pat_out), 32'(q[pos]));
            chk("run_idx", 32'(pat_idx), 32'(pos));
            chk("run_last", 32'(pat_last), 32'(pos == q.size() - 1));
            if (pos == 0) first_seen = pat_out;
            if (pat_ready) begin
              pos++;
              n_acc++;
              if (pos == q.size()) ph = 2;
            end
          end
        end
        2: begin
          chk("fin_done", 32'(done), 1);
          chk("fin_valid", 32'(pat_valid), 0);
          chk("fin_busy", 32'(busy), 0);
          ph = 0;
        end
        default: begin
          chk("bad_err", 32'(err), 1);
          chk("bad_valid", 32'(pat_valid), 0);
          chk("bad_busy", 32'(busy), 0);
          ph = 0;
        end
      endcase
    end
  end

  task automatic run(input int k, input int rmode, input int k_spur);
    @(posedge clk); #2;
    start     = 1'b1;
    k_in      = CW'(k);
    pat_ready = rmode != 0 ? 1'($urandom % 2) : 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (ph == 0) break;
      pat_ready = rmode != 0 ? 1'($urandom % 2) : 1'b1;
      if (k_spur >= 0 && c == 5) begin
        start = 1'b1;
        k_in  = CW'(k_spur);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #2;
    end
    start = 1'b0;
    chk("run_timeout", 32'(ph), 0);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    run(1, 0, -1);
    chk("k1_count", 32'(n_acc), 8);
    chk("k1_first", 32'(first_seen), 32'h01);
    chk("k1_model_last", 32'(q[7]), 32'h80);

    run(2, 0, -1);
    chk("k2_count", 32'(n_acc), 28);
    chk("k2_model_0", 32'(q[0]), 32'h03);
    chk("k2_model_1", 32'(q[1]), 32'h05);
    chk("k2_model_2", 32'(q[2]), 32'h06);
    chk("k2_model_3", 32'(q[3]), 32'h09);
    chk("k2_model_4", 32'(q[4]), 32'h0A);
    chk("k2_model_5", 32'(q[5]), 32'h0C);
    chk("k2_model_6", 32'(q[6]), 32'h11);
    chk("k2_model_27", 32'(q[27]), 32'hC0);

    run(0, 0, -1);
    chk("k0_count", 32'(n_acc), 1);
    chk("k0_word", 32'(first_seen), 32'h00);

    run(8, 0, -1);
    chk("k8_count", 32'(n_acc), 1);
    chk("k8_word", 32'(first_seen), 32'hFF);

    run(9, 0, -1);
    chk("k9_count", 32'(n_acc), 0);

    run(4, 1, 2);
    chk("k4_count", 32'(n_acc), 70);
    chk("k4_binom", 32'(binom(8, 4)), 70);

    for (int r = 0; r < 3; r++) begin
      int kr;
      kr = int'($urandom_range(0, WIDTH));
      run(kr, 1, -1);
      chk("rand_count", 32'(n_acc), 32'(binom(WIDTH, kr)));
    end

    // Abort a k=3 sequence after its 10th word with an asynchronous reset.
    @(posedge clk); #2;
    start     = 1'b1;
    k_in      = CW'(3);
    pat_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (pos >= 10) break;
      @(posedge clk); #2;
    end
    chk("abort_reached", 32'(pos), 10);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(pat_valid), 0);
    chk("abort_out", 32'(pat_out), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_idx", 32'(pat_idx), 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;

    run(3, 0, -1);
    chk("k3_first", 32'(first_seen), 32'h07);
    chk("k3_count", 32'(n_acc), 56);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
